bus_drvr_fifo: RTL

Per-driver transmit FIFO sitting directly upstream of the shared bus. One instance per driver per bus: the driver agent pushes packets in, and the bus pops them out through the `pndng` / `pop` / `D_pop` handshake. The FIFO is show-ahead, depth `fif_Size` (not a power of two), and reports overflow and underflow with drop accounting so the scoreboard can reconcile lost packets.

---
 rtl/bus_drvr_fifo_pkg.sv | 10 +
 rtl/bus_drvr_fifo_if.sv | 26 ++
 rtl/bus_fifo_ptr.sv | 20 ++
 rtl/bus_drvr_fifo.sv | 85 ++++++++
 4 files changed

// File: rtl/bus_drvr_fifo_pkg.sv
// Shared bus-wide sizing: packet width, per-driver FIFO depth, driver and bus counts.
package bus_parameters;
    localparam int bits     = 16;
    localparam int fif_Size = 10;
    localparam int drvrs    = 4;
    localparam int buses    = 1;
    localparam int cnt_w    = $clog2(fif_Size + 1);

    typedef logic [$clog2(fif_Size)-1:0] ptr_t;
endpackage

// File: rtl/bus_drvr_fifo_if.sv
// Driver-to-bus handshake bundle; master is the agent/bus side, slave is the FIFO.
interface bus_drvr_fifo_if #(
    parameter int bits  = bus_parameters::bits,
    parameter int depth = bus_parameters::fif_Size
);
    logic                         push;
    logic [bits-1:0]              D_push;
    logic                         pop;
    logic [bits-1:0]              D_pop;
    logic                         pndng;
    logic                         full;
    logic [$clog2(depth+1)-1:0]   count;
    logic                         ovf;
    logic                         udf;
    logic [7:0]                   drops;

    modport master (
        output push, D_push, pop,
        input  D_pop, pndng, full, count, ovf, udf, drops
    );

    modport slave (
        input  push, D_push, pop,
        output D_pop, pndng, full, count, ovf, udf, drops
    );
endinterface

// File: rtl/bus_fifo_ptr.sv
// FIFO pointer that wraps from depth-1 back to 0, so depth need not be a power of two.
module bus_fifo_ptr #(
    parameter  int depth = 10,
    localparam int w     = $clog2(depth)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [w-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == w'(depth - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/bus_drvr_fifo.sv
// Show-ahead per-driver transmit FIFO with overflow/underflow pulses and saturating drop count.
module bus_drvr_fifo
    import bus_parameters::*;
#(
    parameter int bits  = bus_parameters::bits,
    parameter int depth = bus_parameters::fif_Size
) (
    input  logic              clk,
    input  logic              reset,
    bus_drvr_fifo_if.slave    bus
);

    localparam int ptr_w = $clog2(depth);
    localparam int c_w   = $clog2(depth + 1);

    logic [bits-1:0]  mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [c_w-1:0]   count_q;
    logic             ovf_q;
    logic             udf_q;
    logic [7:0]       drops_q;

    logic empty;
    logic is_full;
    logic wr_en;
    logic rd_en;
    logic drop;

    assign empty   = (count_q == '0);
    assign is_full = (count_q == c_w'(depth));
    // At full a simultaneous pop frees the head slot, so the push is still taken.
    assign wr_en   = bus.push && (!is_full || bus.pop);
    assign rd_en   = bus.pop && !empty;
    assign drop    = bus.push && is_full && !bus.pop;

    bus_fifo_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    bus_fifo_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_ptr] <= bus.D_push;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            ovf_q <= drop;
            udf_q <= bus.pop && empty;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop && drops_q != 8'hFF) begin
                drops_q <= drops_q + 1'b1;
            end
        end
    end

    assign bus.pndng = !empty;
    assign bus.full  = is_full;
    assign bus.count = count_q;
    assign bus.D_pop = empty ? '0 : mem[rd_ptr];
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
    assign bus.drops = drops_q;

endmodule
